key_matrix_scan: RTL and testbench

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

---
 rtl/key_scan_pkg.sv | 30 +++
 rtl/key_scan_tick.sv | 27 ++
 rtl/key_matrix_scan.sv | 122 ++++++++++++
 tb/tb_key_matrix_scan.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: widths, state encoding and
// the small index/rotation helpers used when latching and advancing columns.
package key_scan_pkg;

    localparam int KEY_W = 4;
    localparam int IDX_W = $clog2(KEY_W);
    localparam logic [KEY_W-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } scan_state_t;

    // Index of the lowest zero bit; bit 0 wins when several lines are low.
    function automatic logic [IDX_W-1:0] low_index(input logic [KEY_W-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (!vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [KEY_W-1:0] rotate_col(input logic [KEY_W-1:0] col);
        return {col[KEY_W-2:0], col[KEY_W-1]};
    endfunction

endpackage

// File: rtl/key_scan_tick.sv
// Free-running slot timer: pulses tick for one cycle every SCAN_DIV clocks.
module key_scan_tick #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: walks a low column across the matrix, debounces presses
// and releases on slot ticks, and reports the accepted key as row*4+col.
module key_matrix_scan
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [KEY_W-1:0]     key_row,
    output logic [KEY_W-1:0]     key_col,
    output logic [2*IDX_W-1:0]   key_code,
    output logic                 key_valid,
    output logic                 key_down
);

    // The counter only ever holds 0..DEBOUNCE_CNT-1; reaching the limit is
    // detected one step early so it never needs the extra bit.
    localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CNT - 1);

    logic [KEY_W-1:0] row_meta;
    logic [KEY_W-1:0] row_s;
    logic             tick;
    logic             pressed;
    scan_state_t      state;
    logic [DW-1:0]    deb_cnt;
    logic [KEY_W-1:0] row_vec;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;

    key_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= key_row;
            row_s    <= row_meta;
        end
    end

    assign pressed = ~&row_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= SCAN;
            key_col   <= COL_RESET;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            deb_cnt   <= '0;
            row_vec   <= '1;
            row_idx   <= '0;
            col_idx   <= '0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (pressed) begin
                            row_vec <= row_s;
                            row_idx <= low_index(row_s);
                            col_idx <= low_index(key_col);
                            deb_cnt <= DW'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            key_col <= rotate_col(key_col);
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s != row_vec) begin
                            deb_cnt <= '0;
                            key_col <= rotate_col(key_col);
                            state   <= SCAN;
                        end else if (deb_cnt == DLAST) begin
                            key_code  <= {row_idx, col_idx};
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            deb_cnt   <= '0;
                            state     <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    // Other keys pressed while one is held are deliberately ignored.
                    HELD: begin
                        if (!pressed) begin
                            deb_cnt <= DW'(1);
                            state   <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (pressed) begin
                            deb_cnt <= '0;
                            state   <= HELD;
                        end else if (deb_cnt == DLAST) begin
                            key_down <= 1'b0;
                            deb_cnt  <= '0;
                            key_col  <= rotate_col(key_col);
                            state    <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench: a 4x4 switch matrix drives key_row from key_col, and
// each scenario predicts codes and column positions from the scanning rules.
module tb_key_matrix_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic       clk;
    logic       resetn;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [3:0] sw [4];
    int         tests;
    int         fails;
    int         ecount;
    int         valid_cnt;
    bit         mon_en;

    key_matrix_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A closed switch pulls its row low whenever its column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (sw[r][c] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    // Slot ticks are taken on every SCAN_DIV-th edge after the last reset edge.
    always @(posedge clk) begin
        if (!resetn) ecount <= 0;
        else         ecount <= ecount + 1;
        if (key_valid) valid_cnt <= valid_cnt + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if ($countones(~key_col) != 1) begin
                fails++;
                $display("[TB] FAIL col_onehot: got %b, expected exactly one low bit", key_col);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic clear_sw();
        for (int r = 0; r < 4; r++) sw[r] = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Returns at the negedge just after the next slot tick edge.
    task automatic slot();
        do @(negedge clk); while (ecount % SCAN_DIV != 0);
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (key_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_fall(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (!key_down) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        resetn = 1'b0;
        clear_sw();
        sw[0][0] = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        tests += 4;
        if (key_col !== 4'b1110) begin fails++; $display("[TB] FAIL reset_col: got %b, expected 1110", key_col); end
        if (key_code !== 4'h0) begin fails++; $display("[TB] FAIL reset_code: got %h, expected 0", key_code); end
        if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b, expected 0", key_valid); end
        if (key_down !== 1'b0) begin fails++; $display("[TB] FAIL reset_down: got %b, expected 0", key_down); end
        clear_sw();
        resetn = 1'b1;
        exp_col = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            slot();
            exp_col = {exp_col[2:0], exp_col[3]};
            tests++;
            if (key_col !== exp_col) begin fails++; $display("[TB] FAIL idle_rotate: got %b, expected %b", key_col, exp_col); end
        end
    endtask

    task automatic test_single_key();
        int v0;
        bit seen;
        do_reset();
        clear_sw();
        v0 = valid_cnt;
        sw[1][2] = 1'b1;
        wait_valid(seen);
        tests += 4;
        if (!seen) begin fails++; $display("[TB] FAIL single_valid: got no pulse, expected one"); end
        if (key_code !== 4'd6) begin fails++; $display("[TB] FAIL single_code: got %0d, expected 6", key_code); end
        if (key_down !== 1'b1) begin fails++; $display("[TB] FAIL single_down: got %b, expected 1", key_down); end
        if (key_col !== 4'b1011) begin fails++; $display("[TB] FAIL single_col: got %b, expected 1011", key_col); end
        @(negedge clk);
        tests++;
        if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse_width: got %b, expected 0", key_valid); end
        // A second key in the same column while held must not be reported.
        sw[0][2] = 1'b1;
        repeat (40) @(negedge clk);
        tests += 4;
        if (valid_cnt - v0 != 1) begin fails++; $display("[TB] FAIL single_count: got %0d, expected 1", valid_cnt - v0); end
        if (key_code !== 4'd6) begin fails++; $display("[TB] FAIL held_code: got %0d, expected 6", key_code); end
        if (key_col !== 4'b1011) begin fails++; $display("[TB] FAIL held_col: got %b, expected 1011", key_col); end
        if (key_down !== 1'b1) begin fails++; $display("[TB] FAIL held_down: got %b, expected 1", key_down); end
        clear_sw();
        wait_fall(seen);
        tests += 3;
        if (!seen) begin fails++; $display("[TB] FAIL single_release: got key_down stuck, expected fall"); end
        if (key_col !== 4'b0111) begin fails++; $display("[TB] FAIL release_col: got %b, expected 0111", key_col); end
        if (valid_cnt - v0 != 1) begin fails++; $display("[TB] FAIL release_count: got %0d, expected 1", valid_cnt - v0); end
    endtask

    task automatic test_short_press();
        int v0;
        do_reset();
        clear_sw();
        v0 = valid_cnt;
        slot();
        tests++;
        if (key_col !== 4'b1101) begin fails++; $display("[TB] FAIL short_start_col: got %b, expected 1101", key_col); end
        sw[0][1] = 1'b1;
        slot();
        clear_sw();
        tests++;
        if (key_col !== 4'b1101) begin fails++; $display("[TB] FAIL short_frozen_col: got %b, expected 1101", key_col); end
        slot();
        tests++;
        if (key_col !== 4'b1011) begin fails++; $display("[TB] FAIL short_resume_col: got %b, expected 1011", key_col); end
        repeat (30) @(negedge clk);
        tests += 2;
        if (valid_cnt != v0) begin fails++; $display("[TB] FAIL short_no_valid: got %0d, expected 0", valid_cnt - v0); end
        if (key_down !== 1'b0) begin fails++; $display("[TB] FAIL short_down: got %b, expected 0", key_down); end
    endtask

    task automatic test_priority();
        int v0;
        bit seen;
        do_reset();
        clear_sw();
        v0 = valid_cnt;
        sw[0][3] = 1'b1;
        sw[3][3] = 1'b1;
        wait_valid(seen);
        tests += 2;
        if (!seen) begin fails++; $display("[TB] FAIL prio_valid: got no pulse, expected one"); end
        if (key_code !== 4'd3) begin fails++; $display("[TB] FAIL prio_code: got %0d, expected 3", key_code); end
        repeat (20) @(negedge clk);
        clear_sw();
        wait_fall(seen);
        tests += 2;
        if (valid_cnt - v0 != 1) begin fails++; $display("[TB] FAIL prio_count: got %0d, expected 1", valid_cnt - v0); end
        if (key_col !== 4'b1110) begin fails++; $display("[TB] FAIL prio_release_col: got %b, expected 1110", key_col); end
    endtask

    task automatic test_release_glitch();
        int v0;
        bit seen;
        do_reset();
        clear_sw();
        v0 = valid_cnt;
        sw[3][3] = 1'b1;
        wait_valid(seen);
        tests += 2;
        if (!seen) begin fails++; $display("[TB] FAIL glitch_valid: got no pulse, expected one"); end
        if (key_code !== 4'd15) begin fails++; $display("[TB] FAIL glitch_code: got %0d, expected 15", key_code); end
        slot();
        clear_sw();
        slot();
        sw[3][3] = 1'b1;
        slot();
        clear_sw();
        tests++;
        if (key_down !== 1'b1) begin fails++; $display("[TB] FAIL glitch_down_early: got %b, expected 1", key_down); end
        slot();
        slot();
        tests++;
        if (key_down !== 1'b1) begin fails++; $display("[TB] FAIL glitch_down_two: got %b, expected 1", key_down); end
        slot();
        tests += 4;
        if (key_down !== 1'b0) begin fails++; $display("[TB] FAIL glitch_down_three: got %b, expected 0", key_down); end
        if (key_col !== 4'b1110) begin fails++; $display("[TB] FAIL glitch_col: got %b, expected 1110", key_col); end
        if (key_code !== 4'd15) begin fails++; $display("[TB] FAIL glitch_code_hold: got %0d, expected 15", key_code); end
        if (valid_cnt - v0 != 1) begin fails++; $display("[TB] FAIL glitch_count: got %0d, expected 1", valid_cnt - v0); end
    endtask

    task automatic test_reset_debounce();
        int v0;
        bit seen;
        do_reset();
        clear_sw();
        sw[2][1] = 1'b1;
        wait_valid(seen);
        tests++;
        if (key_code !== 4'd9) begin fails++; $display("[TB] FAIL prereset_code: got %0d, expected 9", key_code); end
        clear_sw();
        wait_fall(seen);
        tests++;
        if (key_col !== 4'b1011) begin fails++; $display("[TB] FAIL prereset_col: got %b, expected 1011", key_col); end
        v0 = valid_cnt;
        sw[1][2] = 1'b1;
        slot();
        slot();
        tests++;
        if (key_col !== 4'b1011) begin fails++; $display("[TB] FAIL debounce_frozen: got %b, expected 1011", key_col); end
        resetn = 1'b0;
        clear_sw();
        @(negedge clk);
        resetn = 1'b1;
        tests += 4;
        if (key_col !== 4'b1110) begin fails++; $display("[TB] FAIL abort_col: got %b, expected 1110", key_col); end
        if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_valid: got %b, expected 0", key_valid); end
        if (key_down !== 1'b0) begin fails++; $display("[TB] FAIL abort_down: got %b, expected 0", key_down); end
        if (key_code !== 4'd0) begin fails++; $display("[TB] FAIL abort_code: got %0d, expected 0", key_code); end
        repeat (40) @(negedge clk);
        tests++;
        if (valid_cnt != v0) begin fails++; $display("[TB] FAIL abort_no_valid: got %0d, expected 0", valid_cnt - v0); end
    endtask

    // Random single-column key groups: the reported key is the lowest closed
    // row in that column, and release moves the scan to the following column.
    task automatic test_random();
        int         c;
        int         row;
        int         v0;
        bit         seen;
        logic [3:0] mask;
        logic [3:0] exp_code;
        logic [3:0] exp_col;
        logic [3:0] next_col;
        do_reset();
        clear_sw();
        for (int n = 0; n < 10; n++) begin
            c    = int'($urandom_range(3, 0));
            mask = 4'($urandom_range(15, 1));
            row  = 0;
            while (!mask[row]) row++;
            exp_code = 4'(row * 4 + c);
            exp_col  = 4'b1111 ^ (4'b0001 << c);
            next_col = 4'b1111 ^ (4'b0001 << ((c + 1) % 4));
            v0 = valid_cnt;
            for (int r = 0; r < 4; r++) sw[r][c] = mask[r];
            wait_valid(seen);
            tests += 3;
            if (!seen) begin fails++; $display("[TB] FAIL rand_valid[%0d]: got no pulse, expected one", n); end
            if (key_code !== exp_code) begin fails++; $display("[TB] FAIL rand_code[%0d]: got %0d, expected %0d", n, key_code, exp_code); end
            if (key_col !== exp_col) begin fails++; $display("[TB] FAIL rand_col[%0d]: got %b, expected %b", n, key_col, exp_col); end
            repeat ($urandom_range(40, 0)) @(negedge clk);
            sw[$urandom_range(3, 0)][c] = 1'b1;
            repeat ($urandom_range(20, 0)) @(negedge clk);
            clear_sw();
            wait_fall(seen);
            tests += 3;
            if (!seen) begin fails++; $display("[TB] FAIL rand_release[%0d]: got key_down stuck, expected fall", n); end
            if (key_col !== next_col) begin fails++; $display("[TB] FAIL rand_next_col[%0d]: got %b, expected %b", n, key_col, next_col); end
            if (valid_cnt - v0 != 1) begin fails++; $display("[TB] FAIL rand_count[%0d]: got %0d, expected 1", n, valid_cnt - v0); end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        valid_cnt = 0;
        ecount    = 0;
        mon_en    = 1'b0;
        resetn    = 1'b0;
        for (int r = 0; r < 4; r++) sw[r] = 4'b0000;
        test_reset();
        test_single_key();
        test_short_press();
        test_priority();
        test_release_glitch();
        test_reset_debounce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
